// File: rtl/epd_rr_arbiter.sv
// Round-robin arbiter that multiplexes NPORTS byte-stream sources onto a single
// packet detector, one packet at a time, with a forced idle gap between packets.
module epd_rr_arbiter #(
  parameter int NPORTS        = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_BYTES     = 1518
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     req,
  input  logic [8*NPORTS-1:0]   port_data,
  input  logic [NPORTS-1:0]     port_ctrl,
  output logic [NPORTS-1:0]     grant,
  output logic [7:0]            epd_data,
  output logic                  epd_ctrl,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  err,
  output logic [7:0]            pkt_count
);

  localparam int PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [PTR_W-1:0]  last_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic              seen_ctrl;
  logic [10:0]       byte_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              sel_ctrl;
  logic [7:0]        sel_data;
  logic              start_xfer;
  logic              end_normal;
  logic              end_abort;

  // last_ptr always holds the granted port while in XFER, so it doubles as the mux select.
  assign sel_ctrl = port_ctrl[last_ptr];
  assign sel_data = port_data[{last_ptr, 3'b000} +: 8];
  assign busy     = (state != IDLE);

  // Round-robin scan starting just after the most recent winner.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = last_ptr;
    cand      = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand = int'(last_ptr) + k;
      if (cand >= NPORTS) cand = cand - NPORTS;
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    start_xfer = 1'b0;
    end_normal = 1'b0;
    end_abort  = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          next_state = XFER;
          start_xfer = 1'b1;
        end
      end
      XFER: begin
        // Normal end takes priority over either abort condition.
        if (seen_ctrl && !sel_ctrl)
          end_normal = 1'b1;
        else if (sel_ctrl && (byte_cnt == 11'(MAX_BYTES)))
          end_abort = 1'b1;
        else if (!seen_ctrl && !sel_ctrl && (wait_cnt == WAIT_W'(START_TIMEOUT - 1)))
          end_abort = 1'b1;
        if (end_normal || end_abort) next_state = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant     <= '0;
      last_ptr  <= PTR_W'(NPORTS - 1);
      epd_data  <= 8'h00;
      epd_ctrl  <= 1'b0;
      pkt_done  <= 1'b0;
      err       <= 1'b0;
      pkt_count <= 8'h00;
      seen_ctrl <= 1'b0;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      pkt_done <= end_normal;
      err      <= end_abort;
      epd_data <= 8'h00;
      epd_ctrl <= 1'b0;
      gap_cnt  <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (start_xfer) begin
        grant     <= NPORTS'(1) << win_idx;
        last_ptr  <= win_idx;
        seen_ctrl <= 1'b0;
        byte_cnt  <= '0;
        wait_cnt  <= '0;
      end

      if (state == XFER) begin
        if (end_normal || end_abort) begin
          // The oversize byte is dropped here: epd outputs fall back to zero.
          grant <= '0;
        end else begin
          epd_data <= sel_data;
          epd_ctrl <= sel_ctrl;
          if (sel_ctrl) begin
            seen_ctrl <= 1'b1;
            byte_cnt  <= byte_cnt + 11'd1;
          end
          if (!seen_ctrl) wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end

      if (end_normal) pkt_count <= pkt_count + 8'd1;
    end
  end

endmodule

// File: doc/epd_rr_arbiter.md
EPD_RR_ARBITER -- requirements
Module: epd_rr_arbiter

Interface
REQ-001 Parameter NPORTS, default 4: number of byte-stream source ports sharing the single packet detector.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles forced on the detector between packets.
REQ-003 Parameter START_TIMEOUT, default 16: maximum cycles from grant to first control-high byte.
REQ-004 Parameter MAX_BYTES, default 1518: maximum control-high bytes per packet.
REQ-005 clock  input  1  clock; all logic is clocked on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 req  input  NPORTS  per-port "packet pending" request.
REQ-008 port_data  input  8*NPORTS  per-port byte; port i occupies bits [8i+7:8i].
REQ-009 port_ctrl  input  NPORTS  per-port control; high marks an in-packet byte.
REQ-010 grant  output  NPORTS  one-hot grant; all-zero when no port is granted.
REQ-011 epd_data  output  8  byte forwarded to the detector.
REQ-012 epd_ctrl  output  1  control forwarded to the detector.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 pkt_done  output  1  one-cycle pulse when a packet completes normally.
REQ-015 err  output  1  one-cycle pulse when a packet is aborted (timeout or oversize).
REQ-016 pkt_count  output  8  count of normally completed packets.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, XFER and GAP.
REQ-018 In IDLE with req nonzero, the block SHALL pick a winner and, next cycle, enter XFER with grant=onehot(winner) and last_ptr=winner.
REQ-019 Winner SHALL be the first requesting port scanning (last_ptr+1) mod NPORTS upward with wrap (round-robin).
REQ-020 In IDLE with req all-zero, the block SHALL stay in IDLE with grant=0.
REQ-021 In XFER, epd_data/epd_ctrl SHALL be the granted port's port_data/port_ctrl registered, giving exactly 1-cycle latency.
REQ-022 In XFER, seen_ctrl SHALL be set on the first cycle the granted port_ctrl is high.
REQ-023 In XFER, byte_cnt (11 bits) SHALL increment on each cycle the granted port_ctrl is high.
REQ-024 Normal end: seen_ctrl=1 and granted port_ctrl=0 -> GAP next cycle, grant=0, pkt_done pulse, pkt_count+1 with wrap 255->0.
REQ-025 Timeout: START_TIMEOUT cycles in XFER with seen_ctrl=0 -> GAP, grant=0, err pulse.
REQ-026 Oversize: granted port_ctrl high when byte_cnt==MAX_BYTES -> GAP, grant=0, err pulse; that byte SHALL NOT be forwarded, so epd_ctrl=0 from the following cycle.
REQ-027 In XFER, req changes on any port SHALL be ignored; only port_ctrl of the granted port ends the transfer.
REQ-028 Non-granted ports' data/ctrl SHALL never reach epd_data/epd_ctrl.
REQ-029 In GAP, epd_ctrl SHALL be 0 and epd_data 8'h00 for exactly GAP_CYCLES cycles, then the FSM SHALL return to IDLE.
REQ-030 If req is pending on the GAP exit cycle, arbitration SHALL occur in the following IDLE cycle; IDLE lasts at least 1 cycle.
REQ-031 If the normal-end and timeout/oversize conditions coincide, normal end SHALL win and err SHALL NOT pulse.
REQ-032 pkt_done and err SHALL never both be high in the same cycle.
REQ-033 On entry to XFER, seen_ctrl, byte_cnt and wait_cnt SHALL be cleared.

Reset
REQ-034 While reset is high, the block SHALL force: state=IDLE, grant=0, epd_data=8'h00, epd_ctrl=0, busy=0, pkt_done=0, err=0, pkt_count=0, last_ptr=NPORTS-1.
REQ-035 Reset asserted mid-XFER SHALL drop grant and epd_ctrl on the next edge and discard the packet without a pkt_done or err pulse.

Verification
REQ-036 Bench: req=4'b0001; port0 sends 64 ctrl-high bytes -> grant=0001, epd_data matches port0 delayed 1 cycle, one pkt_done, pkt_count=1, then 2 GAP cycles.
REQ-037 Bench: req=4'b1111 held for 8 packets -> grant order 0,1,2,3,0,1,2,3; pkt_count=8.
REQ-038 Bench: port2 granted, ctrl never rises -> err pulse on the 16th XFER cycle, grant=0, pkt_count unchanged.
REQ-039 Bench: port1 sends 1519 ctrl-high bytes -> exactly 1518 forwarded bytes with epd_ctrl=1, err pulse, no pkt_done.
REQ-040 Bench: reset asserted 10 bytes into a port3 packet -> next cycle grant=0, epd_ctrl=0, pkt_count=0; after release, req=4'b1001 -> port0 granted first.
REQ-041 Bench: port0 ctrl toggling while ports 1-3 toggle req during XFER -> epd outputs carry only port0 bytes; the packet ends at port0 ctrl fall.
